hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline control block for the 5-stage 64-bit RISC-V core. It drives the hold and flush inputs of the pipeline registers and produces the EX-stage forwarding selects.
- Reads destination/control fields out of ID/EX, EX/MEM and MEM/WB, and the source fields of the instruction in ID.
- Decides stalls (bubble into ID/EX), wrong-path flushes on taken branches, and operand forwarding.
- Keeps a small FSM, a consecutive-stall watchdog and saturating performance counters.

## Interface
- CNT_W, 32, width of performance counters
- MAX_STALL, 3, consecutive stall cycles allowed before `hazard_err` sets
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- if_id_rs1, if_id_rs2  in  5  source registers of instruction in ID
- if_id_use_rs1, if_id_use_rs2  in  1  instruction in ID actually reads rs1/rs2
- id_ex_rs1, id_ex_rs2  in  5  source registers of instruction in EX
- id_ex_rd  in  5  EX destination
- id_ex_regwrite, id_ex_memread  in  1  EX control
- ex_mem_rd  in  5  MEM destination
- ex_mem_regwrite  in  1  MEM control
- mem_wb_rd  in  5  WB destination
- mem_wb_regwrite  in  1  WB control
- branch_taken  in  1  taken branch resolved in MEM this cycle
- pc_write  out  1  0 = hold PC
- if_id_write  out  1  0 = hold IF/ID
- id_ex_bubble  out  1  1 = load zero controls into ID/EX
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  zero the respective register
- forward_a, forward_b  out  2  00 regfile, 10 EX/MEM, 01 MEM/WB
- hazard_err  out  1  sticky watchdog flag
- stall_cycles, flush_events  out  CNT_W  saturating counters

## Operation
- Matches with rd = x0 never create a hazard and never forward.
- Hazard condition (FORWARDING_EN defined): id_ex_memread && id_ex_regwrite && id_ex_rd matches a used rs in ID.
- Stall (hazard, no branch_taken, state ≠ FLUSH):
  - pc_write = 0, if_id_write = 0, id_ex_bubble = 1
  - all flushes = 0
- branch_taken has priority over any stall:
  - all three flushes = 1, pc_write = 1, if_id_write = 1, id_ex_bubble = 0
- Forwarding for the instruction in EX:
  - EX/MEM match (ex_mem_regwrite) selects 10.
  - Otherwise MEM/WB match (mem_wb_regwrite) selects 01.
  - Otherwise 00. EX/MEM wins when both match.
- FSM states RUN, STALL, FLUSH:
  - RUN→STALL when a stall is issued.
  - STALL→STALL while the stall persists; STALL→RUN when it clears.
  - Any state→FLUSH on branch_taken. FLUSH→RUN after one cycle; FLUSH→FLUSH if branch_taken is asserted again.
  - In FLUSH, hazard detection is suppressed (no stall).
- Watchdog: stall_run counts consecutive stall cycles and clears on leaving STALL. When stall_run would exceed MAX_STALL, hazard_err sets; it clears only on reset.
- Counters:
  - stall_cycles increments on every cycle with id_ex_bubble = 1.
  - flush_events increments on every cycle with branch_taken = 1.
  - Both saturate at all-ones.

## Timing
- Stall, flush and forward outputs are combinational from the current inputs and the registered state, valid in the same cycle. Zero-cycle latency.
- State, stall_run, hazard_err and counters update on posedge clk.
- Reset values and behaviour while reset = 1:
  - state RUN, pc_write = 1, if_id_write = 1, id_ex_bubble = 0, flushes 0, forward 00, hazard_err 0, counters 0.
  - Outputs are forced to these values regardless of the other inputs.
- Reset asserted mid-stall or mid-flush aborts the operation at the next edge; there is no residual bubble or flush.
- Load-use with forwarding: exactly 1 bubble cycle, then the dependent instruction forwards 01 in EX.

## Configuration
- FORWARDING_EN defined: forwarding active; stalls only on load-use.
- FORWARDING_EN undefined:
  - forward_a/forward_b are tied to 00.
  - A stall is issued whenever a used rs in ID matches id_ex_rd (id_ex_regwrite), ex_mem_rd (ex_mem_regwrite) or mem_wb_rd (mem_wb_regwrite). The register file has no write-through.
  - A dependent instruction stalls up to 3 cycles. MAX_STALL default 3 keeps hazard_err clear.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN, STALL, FLUSH)
  - forward-select constants FWD_RF = 2'b00, FWD_MEM_WB = 2'b01, FWD_EX_MEM = 2'b10
- One sub-module, forward_sel: a combinational rs/rd comparator returning the 2-bit select, instanced once per operand.

## Test plan
- Load-use stall: id_ex_memread = 1, id_ex_regwrite = 1, id_ex_rd = 5, if_id_rs1 = 5 (used) -> one cycle with pc_write = 0 and id_ex_bubble = 1. Next cycle, with id_ex_memread now 0 and mem_wb_rd = 5, id_ex_rs1 = 5 -> forward_a = 01; stall_cycles = 1.
- Double match: ex_mem_rd = mem_wb_rd = 7, both regwrite, id_ex_rs2 = 7 -> forward_b = 10. With rd = 0 instead -> forward_b = 00.
- Branch over stall: load-use hazard and branch_taken in the same cycle -> all flushes = 1, id_ex_bubble = 0, pc_write = 1. Next cycle state = FLUSH and the hazard is ignored; flush_events = 1.
- Without FORWARDING_EN: id_ex_rd = 3 (regwrite), if_id_rs1 = 3 used, then the instruction advances through EX/MEM/WB -> 3 consecutive stall cycles, hazard_err stays 0.
- Watchdog: hold the load-use hazard inputs static for 5 cycles -> hazard_err = 1 after cycle 4 and stays set until reset.
- Reset mid-stall: reset = 1 during a STALL cycle -> outputs forced to reset values that same cycle; after the edge state = RUN, counters = 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding control block.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

  // True when a writing producer targets a register the ID instruction reads; x0 never matches.
  function automatic logic rs_hit(logic [4:0] rs1, logic use1, logic [4:0] rs2, logic use2,
                                  logic [4:0] rd, logic we);
    return we && (rd != 5'd0) && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
  endfunction
endpackage

// File: rtl/hazard_ctrl_forward_sel.sv
// Per-operand forwarding select for the instruction in EX; EX/MEM beats MEM/WB.
module forward_sel
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] ex_mem_rd,
  input  logic       ex_mem_regwrite,
  input  logic [4:0] mem_wb_rd,
  input  logic       mem_wb_regwrite,
  output logic [1:0] sel
);
  always_comb begin
    sel = FWD_RF;
    if (ex_mem_regwrite && ex_mem_rd != 5'd0 && ex_mem_rd == rs)
      sel = FWD_EX_MEM;
    else if (mem_wb_regwrite && mem_wb_rd != 5'd0 && mem_wb_rd == rs)
      sel = FWD_MEM_WB;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward control for the 5-stage pipeline.
// Build option: define FORWARDING_EN to enable operand forwarding (load-use stalls only).
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int MAX_STALL = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_use_rs1,
  input  logic             if_id_use_rs2,
  input  logic [4:0]       id_ex_rs1,
  input  logic [4:0]       id_ex_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_regwrite,
  input  logic             id_ex_memread,
  input  logic [4:0]       ex_mem_rd,
  input  logic             ex_mem_regwrite,
  input  logic [4:0]       mem_wb_rd,
  input  logic             mem_wb_regwrite,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             hazard_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);
`ifdef FORWARDING_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif
  localparam int              RUN_W   = $clog2(MAX_STALL + 2);
  localparam logic [RUN_W-1:0] MAX_RUN = RUN_W'(MAX_STALL);

  state_t           state;
  logic [RUN_W-1:0] stall_run;
  logic             err_q;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             load_use, any_dep, hazard, stall, flush;

  logic [1:0][4:0] ex_rs;
  logic [1:0][1:0] sel;
  assign ex_rs = {id_ex_rs2, id_ex_rs1};

  generate
    for (genvar i = 0; i < 2; i++) begin : g_fwd
      forward_sel u_fwd (
        .rs              (ex_rs[i]),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_regwrite (ex_mem_regwrite),
        .mem_wb_rd       (mem_wb_rd),
        .mem_wb_regwrite (mem_wb_regwrite),
        .sel             (sel[i])
      );
    end
  endgenerate

  // Without forwarding the regfile has no write-through, so any in-flight producer blocks ID.
  always_comb begin
    load_use = id_ex_memread &&
               rs_hit(if_id_rs1, if_id_use_rs1, if_id_rs2, if_id_use_rs2, id_ex_rd, id_ex_regwrite);
    any_dep  = rs_hit(if_id_rs1, if_id_use_rs1, if_id_rs2, if_id_use_rs2, id_ex_rd, id_ex_regwrite) ||
               rs_hit(if_id_rs1, if_id_use_rs1, if_id_rs2, if_id_use_rs2, ex_mem_rd, ex_mem_regwrite) ||
               rs_hit(if_id_rs1, if_id_use_rs1, if_id_rs2, if_id_use_rs2, mem_wb_rd, mem_wb_regwrite);
    hazard   = FWD_ON ? load_use : any_dep;
  end

  assign stall = !reset && hazard && !branch_taken && (state != FLUSH);
  assign flush = !reset && branch_taken;

  assign pc_write     = !stall;
  assign if_id_write  = !stall;
  assign id_ex_bubble = stall;
  assign if_id_flush  = flush;
  assign id_ex_flush  = flush;
  assign ex_mem_flush = flush;
  assign forward_a    = (FWD_ON && !reset) ? sel[0] : FWD_RF;
  assign forward_b    = (FWD_ON && !reset) ? sel[1] : FWD_RF;
  assign hazard_err   = err_q && !reset;
  assign stall_cycles = reset ? '0 : stall_cnt;
  assign flush_events = reset ? '0 : flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      stall_run <= '0;
      err_q     <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (branch_taken) state <= FLUSH;
      else if (stall)   state <= STALL;
      else              state <= RUN;

      if (!stall)                  stall_run <= '0;
      else if (stall_run <= MAX_RUN) stall_run <= stall_run + RUN_W'(1);

      // The stall being issued now is run+1; setting once that exceeds the limit.
      if (stall && stall_run >= MAX_RUN) err_q <= 1'b1;

      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_hazard_ctrl;
`ifdef FORWARDING_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif
  localparam int CNT_W = 4;
  localparam int MAX_STALL = 3;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic if_id_use_rs1, if_id_use_rs2, id_ex_regwrite, id_ex_memread;
  logic ex_mem_regwrite, mem_wb_regwrite, branch_taken;
  logic pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush, hazard_err;
  logic [1:0] forward_a, forward_b;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .reset(reset),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
    .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
    .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
    .branch_taken(branch_taken),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .forward_a(forward_a), .forward_b(forward_b), .hazard_err(hazard_err),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  // Reference model: "just flushed" flag, consecutive-stall count, sticky error, counters.
  bit m_flushed;
  int m_run, m_sc, m_fc;
  bit m_err;

  function automatic bit reads(logic [4:0] rd, logic we);
    return we && rd != 0 &&
           ((if_id_use_rs1 && if_id_rs1 == rd) || (if_id_use_rs2 && if_id_rs2 == rd));
  endfunction

  function automatic bit exp_stall();
    bit hz;
    if (FWD_ON) hz = id_ex_memread && reads(id_ex_rd, id_ex_regwrite);
    else hz = reads(id_ex_rd, id_ex_regwrite) || reads(ex_mem_rd, ex_mem_regwrite) ||
              reads(mem_wb_rd, mem_wb_regwrite);
    return !reset && hz && !branch_taken && !m_flushed;
  endfunction

  function automatic logic [1:0] exp_fwd(logic [4:0] rs);
    if (reset || !FWD_ON) return 2'b00;
    if (ex_mem_regwrite && ex_mem_rd != 0 && ex_mem_rd == rs) return 2'b10;
    if (mem_wb_regwrite && mem_wb_rd != 0 && mem_wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_flushed = 0; m_run = 0; m_err = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (exp_stall()) begin
        m_run = m_run + 1;
        if (m_run > MAX_STALL) m_err = 1;
        if (m_sc < CMAX) m_sc = m_sc + 1;
      end else m_run = 0;
      if (branch_taken && m_fc < CMAX) m_fc = m_fc + 1;
      m_flushed = branch_taken;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    {if_id_rs1, if_id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd} = '0;
    {if_id_use_rs1, if_id_use_rs2, id_ex_regwrite, id_ex_memread} = '0;
    {ex_mem_regwrite, mem_wb_regwrite, branch_taken} = '0;
  endtask

  task automatic do_reset();
    clear_inputs(); reset = 1; tick(); reset = 0;
  endtask

  task automatic load_use_inputs();
    id_ex_memread = 1; id_ex_regwrite = 1; id_ex_rd = 5; if_id_rs1 = 5; if_id_use_rs1 = 1;
  endtask

  task automatic test_reset();
    clear_inputs(); load_use_inputs(); branch_taken = 1; reset = 1;
    ex_mem_rd = 9; ex_mem_regwrite = 1; id_ex_rs1 = 9;
    #1;
    checks++;
    if ({pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush,
         forward_a, forward_b, hazard_err} !== 11'b110_000_0000_0)
      $display("FAIL reset_outputs: got %b want 11000000000",
               {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush,
                forward_a, forward_b, hazard_err});
    else passes++;
    tick(); clear_inputs(); reset = 0; #1;
    checks++;
    if (stall_cycles !== 0 || flush_events !== 0 || hazard_err !== 0)
      $display("FAIL reset_counters: got sc=%0d fe=%0d err=%b want 0 0 0",
               stall_cycles, flush_events, hazard_err);
    else passes++;
  endtask

  task automatic test_load_use();
    do_reset(); load_use_inputs(); #1;
    checks++;
    if (pc_write !== 0 || if_id_write !== 0 || id_ex_bubble !== 1 || id_ex_flush !== 0)
      $display("FAIL load_use_stall: got pc=%b ifid=%b bub=%b fl=%b want 0 0 1 0",
               pc_write, if_id_write, id_ex_bubble, id_ex_flush);
    else passes++;
    tick();
    clear_inputs(); mem_wb_rd = 5; mem_wb_regwrite = 1; id_ex_rs1 = 5; #1;
    checks++;
    if (pc_write !== 1 || id_ex_bubble !== 0 || forward_a !== (FWD_ON ? 2'b01 : 2'b00) ||
        stall_cycles !== 1)
      $display("FAIL load_use_next: got pc=%b bub=%b fa=%b sc=%0d want 1 0 %b 1",
               pc_write, id_ex_bubble, forward_a, stall_cycles, FWD_ON ? 2'b01 : 2'b00);
    else passes++;
    tick();
  endtask

  task automatic test_double_match();
    do_reset();
    ex_mem_rd = 7; mem_wb_rd = 7; ex_mem_regwrite = 1; mem_wb_regwrite = 1; id_ex_rs2 = 7; #1;
    checks++;
    if (forward_b !== (FWD_ON ? 2'b10 : 2'b00))
      $display("FAIL double_match: got %b want %b", forward_b, FWD_ON ? 2'b10 : 2'b00);
    else passes++;
    ex_mem_regwrite = 0; #1;
    checks++;
    if (forward_b !== (FWD_ON ? 2'b01 : 2'b00))
      $display("FAIL mem_wb_only: got %b want %b", forward_b, FWD_ON ? 2'b01 : 2'b00);
    else passes++;
    ex_mem_regwrite = 1; ex_mem_rd = 0; mem_wb_rd = 0; id_ex_rs2 = 0; #1;
    checks++;
    if (forward_b !== 2'b00) $display("FAIL x0_no_forward: got %b want 00", forward_b);
    else passes++;
    tick();
  endtask

  task automatic test_branch_over_stall();
    do_reset(); load_use_inputs(); branch_taken = 1; #1;
    checks++;
    if ({if_id_flush, id_ex_flush, ex_mem_flush, id_ex_bubble, pc_write, if_id_write} !== 6'b111011)
      $display("FAIL branch_priority: got %b want 111011",
               {if_id_flush, id_ex_flush, ex_mem_flush, id_ex_bubble, pc_write, if_id_write});
    else passes++;
    tick(); branch_taken = 0; #1;
    checks++;
    if (id_ex_bubble !== 0 || pc_write !== 1 || id_ex_flush !== 0 || flush_events !== 1)
      $display("FAIL flush_suppress: got bub=%b pc=%b fl=%b fe=%0d want 0 1 0 1",
               id_ex_bubble, pc_write, id_ex_flush, flush_events);
    else passes++;
    tick(); #1;
    checks++;
    if (id_ex_bubble !== 1) $display("FAIL stall_after_flush: got %b want 1", id_ex_bubble);
    else passes++;
    tick();
  endtask

  task automatic test_no_fwd_stall();
    do_reset();
    if_id_rs1 = 3; if_id_use_rs1 = 1; id_ex_rd = 3; id_ex_regwrite = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (id_ex_bubble !== (c < 3))
        $display("FAIL no_fwd_cycle%0d: got bub=%b want %b", c, id_ex_bubble, c < 3);
      else passes++;
      tick();
      // producer advances one stage per stall cycle while a bubble enters EX
      mem_wb_rd = ex_mem_rd; mem_wb_regwrite = ex_mem_regwrite;
      ex_mem_rd = id_ex_rd;  ex_mem_regwrite = id_ex_regwrite;
      id_ex_rd = 0; id_ex_regwrite = 0;
    end
    checks++;
    if (hazard_err !== 0 || stall_cycles !== 3)
      $display("FAIL no_fwd_summary: got err=%b sc=%0d want 0 3", hazard_err, stall_cycles);
    else passes++;
  endtask

  task automatic test_watchdog();
    do_reset(); load_use_inputs();
    for (int c = 1; c <= 5; c++) begin
      tick();
      checks++;
      if (hazard_err !== (c >= 4))
        $display("FAIL watchdog_cycle%0d: got %b want %b", c, hazard_err, c >= 4);
      else passes++;
    end
    clear_inputs(); tick(); tick();
    checks++;
    if (hazard_err !== 1) $display("FAIL watchdog_sticky: got %b want 1", hazard_err);
    else passes++;
    do_reset(); #1;
    checks++;
    if (hazard_err !== 0) $display("FAIL watchdog_reset: got %b want 0", hazard_err);
    else passes++;
  endtask

  task automatic test_reset_mid_stall();
    do_reset(); load_use_inputs(); tick(); #1;
    reset = 1; #1;
    checks++;
    if (pc_write !== 1 || id_ex_bubble !== 0 || stall_cycles !== 0)
      $display("FAIL reset_mid_stall: got pc=%b bub=%b sc=%0d want 1 0 0",
               pc_write, id_ex_bubble, stall_cycles);
    else passes++;
    tick(); reset = 0; clear_inputs(); #1;
    checks++;
    if (id_ex_bubble !== 0 || stall_cycles !== 0 || id_ex_flush !== 0)
      $display("FAIL after_reset_stall: got bub=%b sc=%0d fl=%b want 0 0 0",
               id_ex_bubble, stall_cycles, id_ex_flush);
    else passes++;
  endtask

  task automatic test_saturation();
    do_reset(); branch_taken = 1;
    repeat (CMAX + 3) tick();
    checks++;
    if (flush_events !== CNT_W'(CMAX))
      $display("FAIL flush_saturate: got %0d want %0d", flush_events, CMAX);
    else passes++;
    clear_inputs(); tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 24) == 0);
      if_id_rs1 = 5'($urandom_range(0, 3)); if_id_rs2 = 5'($urandom_range(0, 3));
      id_ex_rs1 = 5'($urandom_range(0, 3)); id_ex_rs2 = 5'($urandom_range(0, 3));
      id_ex_rd  = 5'($urandom_range(0, 3)); ex_mem_rd = 5'($urandom_range(0, 3));
      mem_wb_rd = 5'($urandom_range(0, 3));
      {if_id_use_rs1, if_id_use_rs2, id_ex_regwrite, id_ex_memread} = 4'($urandom);
      {ex_mem_regwrite, mem_wb_regwrite} = 2'($urandom);
      branch_taken = ($urandom_range(0, 7) == 0);
      #1;
      checks++;
      if (id_ex_bubble !== exp_stall() || pc_write !== !exp_stall() ||
          if_id_write !== !exp_stall() || ex_mem_flush !== (!reset && branch_taken) ||
          if_id_flush !== (!reset && branch_taken) || id_ex_flush !== (!reset && branch_taken) ||
          forward_a !== exp_fwd(id_ex_rs1) || forward_b !== exp_fwd(id_ex_rs2))
        $display("FAIL rand_comb%0d: got bub=%b pc=%b fl=%b fa=%b fb=%b want %b %b %b %b %b", n,
                 id_ex_bubble, pc_write, ex_mem_flush, forward_a, forward_b, exp_stall(),
                 !exp_stall(), !reset && branch_taken, exp_fwd(id_ex_rs1), exp_fwd(id_ex_rs2));
      else passes++;
      checks++;
      if (hazard_err !== (!reset && m_err) || stall_cycles !== (reset ? 0 : m_sc) ||
          flush_events !== (reset ? 0 : m_fc))
        $display("FAIL rand_state%0d: got err=%b sc=%0d fe=%0d want %b %0d %0d", n,
                 hazard_err, stall_cycles, flush_events, !reset && m_err,
                 reset ? 0 : m_sc, reset ? 0 : m_fc);
      else passes++;
      tick();
    end
    reset = 0;
  endtask

  initial begin
    clear_inputs(); reset = 1;
    #1;
    test_reset();
    test_load_use();
    if (FWD_ON) test_double_match();
    else test_no_fwd_stall();
    test_branch_over_stall();
    test_watchdog();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, got running want done");
    $fatal(1);
  end
endmodule
